// File: rtl/hash_arbiter.sv
// hash_arbiter: round-robin scheduler sharing one full_hash core among
// N_REQ byte-stream requesters.
//
// Ports:
//   clk, rst                : system clock, async active-high reset
//   req                     : per-requester hash request (sampled in IDLE only)
//   s_byte/s_valid/s_eof    : per-requester byte stream, requester k at [8k+7:8k]
//   s_ready                 : per-requester accept (only the granted bit)
//   gnt                     : registered one-hot grant
//   done                    : one-cycle completion pulse on the granted bit
//   digest, msg_len         : captured core digest and saturating byte count
//   busy                    : high in every state except IDLE
//   core_start              : one-cycle start pulse to the core
//   core_byte/eof/dr        : byte stream towards the core
//   core_rtr                : core ready to receive
//   core_h_ready, core_r_h  : core digest valid / digest value
module hash_arbiter #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   s_byte,
  input  logic [N_REQ-1:0]     s_valid,
  input  logic [N_REQ-1:0]     s_eof,
  output logic [N_REQ-1:0]     s_ready,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [31:0]          digest,
  output logic [LEN_W-1:0]     msg_len,
  output logic                 busy,
  output logic                 core_start,
  output logic [7:0]           core_byte,
  output logic                 core_eof,
  output logic                 core_dr,
  input  logic                 core_rtr,
  input  logic                 core_h_ready,
  input  logic [31:0]          core_r_h
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [IDX_W-1:0]  r_last, r_gidx, w_win_idx;
  logic              w_win_vld;
  logic [N_REQ-1:0]  r_gnt;
  logic [LEN_W-1:0]  r_cnt, r_msg_len;
  logic [31:0]       r_digest;
  logic              w_xfer;

  // Round-robin pick. Offsets are scanned from lowest priority (last itself)
  // to highest (last+1) so the highest-priority requester writes last.
  always_comb begin
    int idx;
    idx       = 0;
    w_win_vld = 1'b0;
    w_win_idx = r_last;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(r_last) + i) % N_REQ;
      if (req[idx]) begin
        w_win_vld = 1'b1;
        w_win_idx = IDX_W'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_win_vld) w_next = S_START;
      S_START:  w_next = S_STREAM;
      S_STREAM: if (w_xfer && core_eof) w_next = S_WAIT;
      S_WAIT:   if (core_h_ready) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic: stream is a pure combinational pass-through of the granted lane
  always_comb begin
    busy       = (r_state != S_IDLE);
    core_start = (r_state == S_START);
    core_dr    = 1'b0;
    core_byte  = 8'h00;
    core_eof   = 1'b0;
    s_ready    = '0;
    done       = '0;
    if (r_state == S_STREAM) begin
      core_dr   = s_valid[r_gidx];
      core_byte = s_byte[{r_gidx, 3'b000} +: 8];
      core_eof  = s_eof[r_gidx];
      s_ready   = r_gnt & {N_REQ{core_rtr}};
    end
    if (r_state == S_DONE) done = r_gnt;
  end

  assign w_xfer  = core_dr & core_rtr;
  assign gnt     = r_gnt;
  assign digest  = r_digest;
  assign msg_len = r_msg_len;

  // Grant, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt     <= '0;
      r_gidx    <= '0;
      r_last    <= IDX_W'(N_REQ - 1);
      r_cnt     <= '0;
      r_digest  <= '0;
      r_msg_len <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_win_vld) begin
          r_gnt  <= N_REQ'(1) << w_win_idx;
          r_gidx <= w_win_idx;
          r_last <= w_win_idx;
        end
        S_START:  r_cnt <= '0;
        // Saturate rather than wrap so oversize messages report all-ones
        S_STREAM: if (w_xfer && (r_cnt != {LEN_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
        S_WAIT: if (core_h_ready) begin
          r_digest  <= core_r_h;
          r_msg_len <= r_cnt;
        end
        S_DONE:   r_gnt <= '0;
        default:  r_gnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_hash_arbiter.sv
module tb_hash_arbiter;
  localparam int N_REQ = 4;
  localparam int LEN_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [8*N_REQ-1:0]  s_byte;
  logic [N_REQ-1:0]    s_valid, s_eof, s_ready, gnt, done;
  logic [31:0]         digest, core_r_h;
  logic [LEN_W-1:0]    msg_len;
  logic                busy, core_start, core_eof, core_dr, core_rtr, core_h_ready;
  logic [7:0]          core_byte;

  int checks   = 0;
  int failures = 0;

  logic [N_REQ-1:0] q_gnt[$];
  logic [8:0]       q_byte[$];   // {eof, byte}
  logic [N_REQ-1:0] q_done[$];
  logic [31:0]      q_dig[$];
  logic [LEN_W-1:0] q_len[$];

  hash_arbiter #(.N_REQ(N_REQ), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .req(req), .s_byte(s_byte), .s_valid(s_valid),
    .s_eof(s_eof), .s_ready(s_ready), .gnt(gnt), .done(done), .digest(digest),
    .msg_len(msg_len), .busy(busy), .core_start(core_start), .core_byte(core_byte),
    .core_eof(core_eof), .core_dr(core_dr), .core_rtr(core_rtr),
    .core_h_ready(core_h_ready), .core_r_h(core_r_h)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents a grant, transfer or done
  initial begin
    logic [N_REQ-1:0] pg, pd, eg;
    logic [8:0] eb;
    pg = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pg = '0; pd = '0;
      end else begin
        chk("gnt_onehot", 64'($onehot0(gnt)), 64'd1);
        chk("sready_only_granted", 64'(s_ready & ~gnt), 64'd0);
        chk("start_with_new_grant", 64'(core_start), 64'(pg == '0 && gnt != '0));
        if (pg == '0 && gnt != '0) begin
          chk("grant_expected", 64'(q_gnt.size() != 0), 64'd1);
          if (q_gnt.size() != 0) begin
            eg = q_gnt.pop_front();
            chk("grant_order", 64'(gnt), 64'(eg));
            chk("busy_on_grant", 64'(busy), 64'd1);
          end
        end
        if (core_dr && core_rtr) begin
          chk("transfer_expected", 64'(q_byte.size() != 0), 64'd1);
          if (q_byte.size() != 0) begin
            eb = q_byte.pop_front();
            chk("core_byte_eof", 64'({core_eof, core_byte}), 64'(eb));
          end
        end
        if (pd != '0) chk("done_one_cycle", 64'(done), 64'd0);
        else if (done != '0) begin
          chk("done_expected", 64'(q_done.size() != 0), 64'd1);
          if (q_done.size() != 0) begin
            chk("done_bit", 64'(done), 64'(q_done.pop_front()));
            chk("digest", 64'(digest), 64'(q_dig.pop_front()));
            chk("msg_len", 64'(msg_len), 64'(q_len.pop_front()));
          end
        end
        pg = gnt; pd = done;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  // Drives one message from requester k and plays the core side.
  task automatic run_msg(input int k, input int n, input logic [7:0] base,
                         input logic [31:0] dig, input logic [3:0] rtr_pat,
                         input logic [3:0] vld_pat, input bit drop,
                         input bit foreign, input bit early_h, input int exp_lat);
    logic [N_REQ-1:0] one_k;
    int t, i, cyc;
    bit xfer;
    one_k = N_REQ'(1) << k;
    q_gnt.push_back(one_k);
    for (int b = 0; b < n; b++) q_byte.push_back({(b == n - 1), base + 8'(b)});
    q_done.push_back(one_k);
    q_dig.push_back(dig);
    q_len.push_back((n > 15) ? 4'hF : 4'(n));

    t = 0;
    while (!gnt[k] && t < 40) begin tick(); t++; end
    chk("grant_seen", 64'(gnt[k]), 64'd1);
    if (!gnt[k]) return;
    if (exp_lat > 0) chk("grant_latency", 64'(t), 64'(exp_lat));
    if (drop) req = '0;

    i = 0; cyc = 0;
    while (i < n && cyc < 300) begin
      s_valid[k] = vld_pat[cyc % 4];
      s_byte[8*k +: 8] = base + 8'(i);
      s_eof[k] = (i == n - 1);
      core_rtr = rtr_pat[cyc % 4];
      core_h_ready = early_h && (cyc == 2);
      core_r_h = early_h ? 32'hDEADBEEF : 32'h0;
      if (foreign) begin
        s_valid[2] = 1'b1; s_eof[2] = 1'b1; s_byte[23:16] = 8'hEE;
        if (i >= 1) req[0] = 1'b0;
      end
      @(negedge clk);
      xfer = s_valid[k] && s_ready[k];
      chk("grant_held", 64'(gnt), 64'(one_k));
      if (foreign) chk("foreign_sready", 64'(s_ready[2]), 64'd0);
      tick();
      if (xfer) i++;
      cyc++;
    end
    chk("stream_complete", 64'(i), 64'(n));
    chk("no_bytes_left", 64'(q_byte.size()), 64'd0);
    s_valid = '0; s_eof = '0; core_rtr = 1'b1; core_h_ready = 1'b0;
    repeat (2) tick();
    core_r_h = dig; core_h_ready = 1'b1;
    tick();
    core_h_ready = 1'b0; core_r_h = 32'h0;
    tick();
    chk("done_consumed", 64'(q_done.size()), 64'd0);
  endtask

  initial begin
    int t;
    rst = 1'b1; req = '0; s_byte = '0; s_valid = '0; s_eof = '0;
    core_rtr = 1'b1; core_h_ready = 1'b0; core_r_h = '0;
    tick();
    chk("reset_outputs", 64'({gnt, done, s_ready, busy, core_start, core_byte,
                              core_eof, core_dr, digest, msg_len}), 64'd0);
    rst = 1'b0;
    tick();

    // Single requester, 'abc'
    req = 4'b0001;
    run_msg(0, 3, 8'h61, 32'h12345678, 4'b1111, 4'b1111, 1, 0, 0, 1);

    // Round-robin from a fresh last pointer with every request held
    do_reset();
    req = 4'b1111;
    run_msg(0, 2, 8'h10, 32'hA0000001, 4'b1111, 4'b1111, 0, 0, 0, 1);
    run_msg(1, 2, 8'h20, 32'hA0000002, 4'b1111, 4'b1111, 0, 0, 0, 1);
    run_msg(2, 2, 8'h30, 32'hA0000003, 4'b1111, 4'b1111, 0, 0, 0, 1);
    run_msg(3, 2, 8'h40, 32'hA0000004, 4'b1111, 4'b1111, 0, 0, 0, 1);
    run_msg(0, 1, 8'h50, 32'hA0000005, 4'b1111, 4'b1111, 1, 0, 0, 1);

    // Back-pressure: rtr 1,0,0,1 and gapped valid, 5 bytes
    req = 4'b0010;
    run_msg(1, 5, 8'h80, 32'hB00B0005, 4'b1001, 4'b1011, 1, 0, 0, 1);

    // req[0] dropped mid-message while requester 2 waves a foreign valid/eof
    req = 4'b0001;
    run_msg(0, 4, 8'h90, 32'hC0DE0004, 4'b1111, 4'b1111, 0, 1, 0, 1);
    req = '0;

    // Early core_h_ready in STREAM and counter saturation at 15
    req = 4'b1000;
    run_msg(3, 20, 8'hA0, 32'h5A7E0014, 4'b1111, 4'b1111, 1, 0, 1, 1);

    // Reset in the middle of a message
    req = 4'b0001;
    q_gnt.push_back(4'b0001);
    q_byte.push_back({1'b0, 8'h30});
    q_byte.push_back({1'b0, 8'h31});
    t = 0;
    while (!gnt[0] && t < 40) begin tick(); t++; end
    chk("midrst_grant_seen", 64'(gnt[0]), 64'd1);
    req = '0; core_rtr = 1'b1;
    s_valid[0] = 1'b1; s_byte[7:0] = 8'h30; s_eof[0] = 1'b0;
    tick();
    tick(); s_byte[7:0] = 8'h31;
    tick();
    rst = 1'b1; #1;
    chk("midrst_outputs", 64'({gnt, done, s_ready, busy, core_start, core_byte,
                               core_eof, core_dr, digest, msg_len}), 64'd0);
    chk("midrst_bytes_seen", 64'(q_byte.size()), 64'd0);
    tick();
    s_valid = '0; rst = 1'b0;
    tick();
    req = 4'b0100;
    run_msg(2, 3, 8'hC0, 32'hFEED0003, 4'b1111, 4'b1111, 1, 0, 0, 1);

    repeat (3) tick();
    chk("q_gnt_empty", 64'(q_gnt.size()), 64'd0);
    chk("q_done_empty", 64'(q_done.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hash_arbiter.md
# hash_arbiter

Round-robin scheduler that shares one `full_hash` core among `N_REQ` byte-stream requesters. It grants the core to one requester at a time and pulses the core's start. It forwards that requester's bytes through the core's `F_dr`/`F_rtr` handshake until end-of-file, then captures the 32-bit digest and the message byte count and returns them with a per-requester done pulse. It sits between the file/DMA front-ends and the single hash instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `LEN_W`, 16: width of the message byte counter.

- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  per-requester request to hash a message; sampled only in IDLE.
- `s_byte`  in  8*N_REQ  per-requester data byte; requester k occupies bits [8k+7:8k].
- `s_valid`  in  N_REQ  per-requester byte valid.
- `s_eof`  in  N_REQ  marks the last byte of the message; qualified by `s_valid`.
- `s_ready`  out  N_REQ  per-requester byte accept; only the granted bit can be 1.
- `gnt`  out  N_REQ  one-hot grant, registered.
- `done`  out  N_REQ  one-cycle pulse on the granted bit when `digest`/`msg_len` are valid.
- `digest`  out  32  captured core digest; holds until the next capture.
- `msg_len`  out  LEN_W  bytes transferred in the last message; saturating.
- `busy`  out  1  high in every state except IDLE.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_byte`  out  8  byte to the core (`Byte`).
- `core_eof`  out  1  end-of-file to the core (`End_of_File`).
- `core_dr`  out  1  data ready to the core (`F_dr`).
- `core_rtr`  in  1  core ready to receive (`F_rtr`).
- `core_h_ready`  in  1  core digest valid (`H_ready`).
- `core_r_h`  in  32  core digest (`R_h`).

## Operation
- FSM states: IDLE, START, STREAM, WAIT_HASH, DONE.
- **Arbitration:**
  - Priority order starts at `(last+1) mod N_REQ`.
  - `last` is the most recently granted index; reset value `N_REQ-1`, so requester 0 wins first.
  - `last` updates when a grant is issued.
- **IDLE:**
  - If `req` is nonzero, register a one-hot `gnt` for the winner, update `last`, and go to START.
  - Otherwise stay in IDLE.
- **START:** `core_start`=1 for exactly this cycle. Clear the byte counter. Go to STREAM.
- **STREAM:** combinational pass-through from the granted index g:
  - `core_dr`=`s_valid[g]`, `core_byte`=`s_byte[g]`, `core_eof`=`s_eof[g]`.
  - `s_ready[g]`=`core_rtr`.
  - A transfer is a cycle with `core_dr` && `core_rtr`. Each transfer increments the counter, saturating at all-ones.
  - A transfer with `core_eof`=1 moves the FSM to WAIT_HASH.
- **WAIT_HASH:**
  - `core_dr`=0 and all `s_ready`=0.
  - On the first cycle with `core_h_ready`=1: latch `core_r_h` into `digest` and the counter into `msg_len`, then go to DONE.
- **DONE:** `done[g]`=1 for one cycle. `gnt` clears at the end of this cycle. Go to IDLE.
- Outside STREAM, `core_dr`, `core_eof` and `core_byte` are 0.
- Non-granted `s_valid`/`s_eof` are ignored, and their `s_ready` bits are 0.
- `req` is not sampled outside IDLE. Deasserting `req[g]` mid-message does not release the grant; only eof ends a grant.
- `core_h_ready` in IDLE, START or STREAM is ignored.
- Zero-length messages are not supported: eof must ride on a valid byte.

## Timing
- **Reset values:**
  - `gnt`, `done`, `s_ready`, `busy` = 0.
  - `core_*` outputs = 0.
  - `digest` = 0, `msg_len` = 0.
  - State = IDLE, `last` = N_REQ-1.
- **Reset mid-operation:** asynchronous return to the values above. No `done` is emitted and the core is re-started only by a new grant.
- **Grant latency:** `req` high in IDLE cycle t gives `gnt`/`busy` in cycle t+1, `core_start` in cycle t+1, and first possible transfer in cycle t+2.
- **Completion:** `core_h_ready` sampled in cycle u gives `done`/`digest`/`msg_len` valid in cycle u+1. Cycle u+2 is IDLE, where the next arbitration happens. Minimum gap between grants is 3 cycles after eof plus the core latency.
- A single requester holding `req` is regranted after each DONE.
- `msg_len` counts the eof byte.
- Stalls: any cycle with `core_rtr`=0 or `s_valid[g]`=0 transfers nothing and does not increment the counter.

## Test plan
- **Single requester:** reset, `req`=0001, stream bytes 0x61,0x62,0x63 (eof on 0x63) with `core_rtr`=1, core model returns `core_r_h`=0x12345678.
  - Required: `core_start` pulse in cycle 1 after req; `done`=0001 for 1 cycle; `digest`=0x12345678; `msg_len`=3.
- **Round-robin:** `req`=1111 held continuously.
  - Required: grant order 0001, 0010, 0100, 1000, 0001; never two bits of `gnt` high.
- **Back-pressure:** toggle `core_rtr` 1,0,0,1 and `s_valid` with gaps during a 5-byte message.
  - Required: exactly 5 transfers observed at the core; `msg_len`=5; no byte duplicated or dropped.
- **Mid-message request drop and foreign valid:**
  - Drop `req[0]` after byte 1 while `s_valid[2]`=1.
  - Required: grant held until eof; `s_ready[2]`=0 throughout; `done`=0001.
- **Early `core_h_ready` and counter saturation:**
  - Pulse `core_h_ready` during STREAM.
  - Required: ignored, no `done`.
  - With `LEN_W`=4, send 20 bytes. Required: `msg_len`=15.
- **Reset mid-message:** assert `rst` during STREAM.
  - Required: all outputs 0 immediately.
  - After release with `req`=0100, required: first grant is 0100.
